// File: rtl/dp_tap_ctrl.sv
// dp_tap_ctrl: JTAG TAP controller for the debug boundary-scan chain.
// All JTAG pins are oversampled in the iclk domain; the FSM steps on detected TCK edges.
module dp_tap_ctrl #(
   parameter int unsigned     IR_W        = 4,
   parameter int unsigned     SYNC_STAGES = 2,
   parameter logic [IR_W-1:0] EXTEST_OP   = '0,
   parameter logic [IR_W-1:0] SAMPLE_OP   = IR_W'(1)
) (
   input  logic            iclk,
   input  logic            iresetn,
   input  logic            tck,
   input  logic            tms,
   input  logic            tdi,
   input  logic            trstn,
   output logic            tdo,
   output logic            tdo_en,
   output logic            bsr_sdi,
   input  logic            bsr_sdo,
   output logic            mode,
   output logic            shift_dr,
   output logic            clk_dr,
   output logic            update_dr,
   output logic [IR_W-1:0] ir_out,
   output logic [3:0]      tap_state
);

   typedef enum logic [3:0] {
      TLR     = 4'hF,
      RTI     = 4'hC,
      SELDR   = 4'h7,
      CAPDR   = 4'h6,
      SHDR    = 4'h2,
      EX1DR   = 4'h1,
      PAUSEDR = 4'h3,
      EX2DR   = 4'h0,
      UPDDR   = 4'h5,
      SELIR   = 4'h4,
      CAPIR   = 4'hE,
      SHIR    = 4'hA,
      EX1IR   = 4'h9,
      PAUSEIR = 4'hB,
      EX2IR   = 4'h8,
      UPDIR   = 4'hD
   } tap_state_t;

   logic [SYNC_STAGES-1:0] tck_sy;
   logic [SYNC_STAGES-1:0] tms_sy;
   logic [SYNC_STAGES-1:0] tdi_sy;
   logic [SYNC_STAGES-1:0] trstn_sy;
   logic                   tck_d;
   logic                   tck_s;
   logic                   tms_s;
   logic                   tdi_s;
   logic                   trstn_s;
   logic                   tck_rise;
   logic                   tck_fall;

   tap_state_t             state;
   tap_state_t             nxt;
   logic [IR_W-1:0]        ir_sh;
   logic [IR_W-1:0]        ir_nxt;
   logic                   bypass;
   logic                   bsr_sel;

   assign tck_s    = tck_sy[SYNC_STAGES-1];
   assign tms_s    = tms_sy[SYNC_STAGES-1];
   assign tdi_s    = tdi_sy[SYNC_STAGES-1];
   assign trstn_s  = trstn_sy[SYNC_STAGES-1];
   assign tck_rise = tck_s & ~tck_d;
   assign tck_fall = ~tck_s & tck_d;

   assign bsr_sel   = (ir_out == EXTEST_OP) | (ir_out == SAMPLE_OP);
   assign bsr_sdi   = tdi_s;
   assign tap_state = state;

   // Bring the asynchronous JTAG pins into iclk and keep last TCK for edge detect
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         tck_sy   <= '0;
         tms_sy   <= '0;
         tdi_sy   <= '0;
         trstn_sy <= '1;
         tck_d    <= 1'b0;
      end else begin
         tck_sy   <= {tck_sy[SYNC_STAGES-2:0], tck};
         tms_sy   <= {tms_sy[SYNC_STAGES-2:0], tms};
         tdi_sy   <= {tdi_sy[SYNC_STAGES-2:0], tdi};
         trstn_sy <= {trstn_sy[SYNC_STAGES-2:0], trstn};
         tck_d    <= tck_s;
      end
   end

   // 1149.1 next-state function, evaluated against the synchronised TMS
   always_comb begin
      nxt = TLR;
      case (state)
         TLR:     nxt = tms_s ? TLR   : RTI;
         RTI:     nxt = tms_s ? SELDR : RTI;
         SELDR:   nxt = tms_s ? SELIR : CAPDR;
         CAPDR:   nxt = tms_s ? EX1DR : SHDR;
         SHDR:    nxt = tms_s ? EX1DR : SHDR;
         EX1DR:   nxt = tms_s ? UPDDR : PAUSEDR;
         PAUSEDR: nxt = tms_s ? EX2DR : PAUSEDR;
         EX2DR:   nxt = tms_s ? UPDDR : SHDR;
         UPDDR:   nxt = tms_s ? SELDR : RTI;
         SELIR:   nxt = tms_s ? TLR   : CAPIR;
         CAPIR:   nxt = tms_s ? EX1IR : SHIR;
         SHIR:    nxt = tms_s ? EX1IR : SHIR;
         EX1IR:   nxt = tms_s ? UPDIR : PAUSEIR;
         PAUSEIR: nxt = tms_s ? EX2IR : PAUSEIR;
         EX2IR:   nxt = tms_s ? UPDIR : SHIR;
         UPDIR:   nxt = tms_s ? SELDR : RTI;
         default: nxt = TLR;
      endcase
   end

   // Next instruction: BYPASS on test reset or TLR entry, else load on Update-IR
   always_comb begin
      ir_nxt = ir_out;
      if (!trstn_s)
         ir_nxt = '1;
      else if (tck_rise && nxt == TLR)
         ir_nxt = '1;
      else if (tck_fall && state == UPDIR)
         ir_nxt = ir_sh;
   end

   // TAP state, IR/bypass shifting, TDO launch and scan-cell strobes
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         state     <= TLR;
         ir_out    <= '1;
         mode      <= 1'b0;
         ir_sh     <= '1;
         bypass    <= 1'b0;
         tdo       <= 1'b0;
         tdo_en    <= 1'b0;
         shift_dr  <= 1'b0;
         clk_dr    <= 1'b0;
         update_dr <= 1'b0;
      end else begin
         ir_out    <= ir_nxt;
         mode      <= (ir_nxt == EXTEST_OP);
         shift_dr  <= bsr_sel & (state == SHDR);
         clk_dr    <= tck_rise & bsr_sel &
                      ((state == CAPDR) | (state == SHDR));
         update_dr <= tck_fall & bsr_sel & (state == UPDDR);
         if (!trstn_s) begin
            state  <= TLR;
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
         end else begin
            if (tck_rise) begin
               state <= nxt;
               if (state == CAPIR)
                  ir_sh <= {{(IR_W-2){1'b1}}, 2'b01};
               else if (state == SHIR)
                  ir_sh <= {tdi_s, ir_sh[IR_W-1:1]};
               if (state == CAPDR)
                  bypass <= 1'b0;
               else if (state == SHDR)
                  bypass <= tdi_s;
            end
            if (tck_fall) begin
               if (state == SHIR) begin
                  tdo    <= ir_sh[0];
                  tdo_en <= 1'b1;
               end else if (state == SHDR) begin
                  tdo    <= bsr_sel ? bsr_sdo : bypass;
                  tdo_en <= 1'b1;
               end else begin
                  tdo    <= 1'b0;
                  tdo_en <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// tb_dp_tap_ctrl: directed checks of the oversampled TAP controller.
// TCK is slow relative to iclk; every pin change lands on an iclk falling edge.
module tb_dp_tap_ctrl;

   logic       iclk;
   logic       iresetn;
   logic       tck;
   logic       tms;
   logic       tdi;
   logic       trstn;
   logic       tdo;
   logic       tdo_en;
   logic       bsr_sdi;
   logic       bsr_sdo;
   logic       mode;
   logic       shift_dr;
   logic       clk_dr;
   logic       update_dr;
   logic [3:0] ir_out;
   logic [3:0] tap_state;

   int errors = 0;
   int checks = 0;
   int n_cap  = 0;
   int n_sh   = 0;
   int n_upd  = 0;
   int n_shl  = 0;

   dp_tap_ctrl dut (
      .iclk      (iclk),
      .iresetn   (iresetn),
      .tck       (tck),
      .tms       (tms),
      .tdi       (tdi),
      .trstn     (trstn),
      .tdo       (tdo),
      .tdo_en    (tdo_en),
      .bsr_sdi   (bsr_sdi),
      .bsr_sdo   (bsr_sdo),
      .mode      (mode),
      .shift_dr  (shift_dr),
      .clk_dr    (clk_dr),
      .update_dr (update_dr),
      .ir_out    (ir_out),
      .tap_state (tap_state)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   // Strobe counters, sampled mid-cycle
   always @(negedge iclk) begin
      if (clk_dr) begin
         if (shift_dr) n_sh = n_sh + 1;
         else          n_cap = n_cap + 1;
      end
      if (update_dr) n_upd = n_upd + 1;
      if (shift_dr)  n_shl = n_shl + 1;
   end

   // One TCK period: TMS/TDI set, rise, fall, then let the fall settle
   task automatic tck_pulse(input logic m, input logic d);
      tms = m;
      tdi = d;
      #40 tck = 1'b1;
      #40 tck = 1'b0;
      #40;
   endtask

   // Load an instruction from RTI and return to RTI
   task automatic shift_ir(input logic [3:0] op);
      tck_pulse(1'b1, 1'b0);
      tck_pulse(1'b1, 1'b0);
      tck_pulse(1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         tck_pulse(i == 3, op[i]);
      tck_pulse(1'b1, 1'b0);
      tck_pulse(1'b0, 1'b0);
   endtask

   task automatic test_reset;
      iresetn = 1'b0;
      tck     = 1'b0;
      tms     = 1'b1;
      tdi     = 1'b0;
      trstn   = 1'b1;
      bsr_sdo = 1'b0;
      repeat (3) @(negedge iclk);
      checks++;
      if (tap_state !== 4'hF) begin
         errors++;
         $display("FAIL reset_state: got %h want F", tap_state);
      end
      checks++;
      if (ir_out !== 4'hF) begin
         errors++;
         $display("FAIL reset_ir: got %h want F", ir_out);
      end
      checks++;
      if ({mode, shift_dr, clk_dr, update_dr, tdo_en, tdo, bsr_sdi} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outs: got %b want 0000000",
                  {mode, shift_dr, clk_dr, update_dr, tdo_en, tdo, bsr_sdi});
      end
      iresetn = 1'b1;
      repeat (2) @(negedge iclk);
   endtask

   task automatic test_tlr_walk;
      logic [3:0] exp_walk [5];
      logic       tms_walk [5];
      exp_walk = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA};
      tms_walk = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tck_pulse(1'b0, 1'b0);
      tck_pulse(1'b1, 1'b0);
      tck_pulse(1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0);
      checks++;
      if (tap_state !== 4'h2) begin
         errors++;
         $display("FAIL walk_to_shdr: got %h want 2", tap_state);
      end
      repeat (5) tck_pulse(1'b1, 1'b0);
      checks++;
      if (tap_state !== 4'hF) begin
         errors++;
         $display("FAIL five_tms_tlr: got %h want F", tap_state);
      end
      for (int i = 0; i < 5; i++) begin
         tck_pulse(tms_walk[i], 1'b0);
         checks++;
         if (tap_state !== exp_walk[i]) begin
            errors++;
            $display("FAIL walk_step%0d: got %h want %h", i, tap_state, exp_walk[i]);
         end
      end
   endtask

   // Continues from Shift-IR: shift in 4'h0 and watch the captured pattern
   task automatic test_ir_scan;
      logic exp_tdo [4];
      exp_tdo = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({tdo_en, tdo} !== {1'b1, exp_tdo[i]}) begin
            errors++;
            $display("FAIL ir_tdo%0d: got en=%b tdo=%b want en=1 tdo=%b",
                     i, tdo_en, tdo, exp_tdo[i]);
         end
         tck_pulse(i == 3, 1'b0);
      end
      checks++;
      if ({tap_state, tdo_en, tdo} !== {4'h9, 2'b00}) begin
         errors++;
         $display("FAIL ir_exit1: got state=%h en=%b tdo=%b want 9 0 0",
                  tap_state, tdo_en, tdo);
      end
      tck_pulse(1'b1, 1'b0);
      checks++;
      if ({tap_state, ir_out, mode} !== {4'hD, 4'h0, 1'b1}) begin
         errors++;
         $display("FAIL ir_update: got state=%h ir=%h mode=%b want D 0 1",
                  tap_state, ir_out, mode);
      end
      tck_pulse(1'b0, 1'b0);
   endtask

   task automatic test_extest_dr;
      int c0, s0, u0;
      c0 = n_cap;
      s0 = n_sh;
      u0 = n_upd;
      tck_pulse(1'b1, 1'b0);
      tck_pulse(1'b0, 1'b0);
      bsr_sdo = 1'b1;
      tck_pulse(1'b0, 1'b1);
      checks++;
      if ({tap_state, shift_dr, tdo_en, tdo, bsr_sdi} !== {4'h2, 4'b1111}) begin
         errors++;
         $display("FAIL ext_enter: got st=%h sh=%b en=%b tdo=%b sdi=%b want 2 1 1 1 1",
                  tap_state, shift_dr, tdo_en, tdo, bsr_sdi);
      end
      for (int k = 0; k < 8; k++) begin
         bsr_sdo = k[0];
         tck_pulse(k == 7, ~k[0]);
         if (k < 7) begin
            checks++;
            if (tdo !== k[0]) begin
               errors++;
               $display("FAIL ext_tdo%0d: got %b want %b", k, tdo, k[0]);
            end
         end
      end
      tck_pulse(1'b1, 1'b0);
      checks++;
      if (tap_state !== 4'h5) begin
         errors++;
         $display("FAIL ext_upd_state: got %h want 5", tap_state);
      end
      tck_pulse(1'b0, 1'b0);
      checks++;
      if ((n_cap - c0) !== 1 || (n_sh - s0) !== 8 || (n_upd - u0) !== 1) begin
         errors++;
         $display("FAIL ext_strobes: got cap=%0d shift=%0d upd=%0d want 1 8 1",
                  n_cap - c0, n_sh - s0, n_upd - u0);
      end
   endtask

   task automatic test_bypass;
      int c0, s0, u0, l0;
      logic exp_tdo [4];
      logic din [4];
      exp_tdo = '{1'b1, 1'b0, 1'b1, 1'b1};
      din     = '{1'b1, 1'b0, 1'b1, 1'b1};
      shift_ir(4'hF);
      checks++;
      if ({ir_out, mode} !== {4'hF, 1'b0}) begin
         errors++;
         $display("FAIL byp_ir: got ir=%h mode=%b want F 0", ir_out, mode);
      end
      c0 = n_cap;
      s0 = n_sh;
      u0 = n_upd;
      l0 = n_shl;
      bsr_sdo = 1'b1;
      tck_pulse(1'b1, 1'b0);
      tck_pulse(1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0);
      checks++;
      if ({tdo_en, tdo} !== 2'b10) begin
         errors++;
         $display("FAIL byp_tdo0: got en=%b tdo=%b want 1 0", tdo_en, tdo);
      end
      for (int i = 0; i < 4; i++) begin
         tck_pulse(1'b0, din[i]);
         checks++;
         if (tdo !== exp_tdo[i]) begin
            errors++;
            $display("FAIL byp_tdo%0d: got %b want %b", i + 1, tdo, exp_tdo[i]);
         end
      end
      tck_pulse(1'b1, 1'b0);
      tck_pulse(1'b1, 1'b0);
      tck_pulse(1'b0, 1'b0);
      checks++;
      if ((n_cap - c0) !== 0 || (n_sh - s0) !== 0 ||
          (n_upd - u0) !== 0 || (n_shl - l0) !== 0) begin
         errors++;
         $display("FAIL byp_strobes: got clk=%0d upd=%0d shl=%0d want 0 0 0",
                  (n_cap - c0) + (n_sh - s0), n_upd - u0, n_shl - l0);
      end
   endtask

   task automatic test_trst;
      shift_ir(4'h0);
      tck_pulse(1'b1, 1'b0);
      tck_pulse(1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0);
      checks++;
      if ({tap_state, tdo_en, mode} !== {4'h2, 2'b11}) begin
         errors++;
         $display("FAIL trst_pre: got st=%h en=%b mode=%b want 2 1 1",
                  tap_state, tdo_en, mode);
      end
      trstn = 1'b0;
      repeat (4) @(negedge iclk);
      checks++;
      if ({tap_state, ir_out, mode, tdo_en} !== {4'hF, 4'hF, 2'b00}) begin
         errors++;
         $display("FAIL trst_tlr: got st=%h ir=%h mode=%b en=%b want F F 0 0",
                  tap_state, ir_out, mode, tdo_en);
      end
      trstn = 1'b1;
      repeat (4) @(negedge iclk);
      tck_pulse(1'b0, 1'b0);
      checks++;
      if (tap_state !== 4'hC) begin
         errors++;
         $display("FAIL trst_resume: got %h want C", tap_state);
      end
   endtask

   initial begin
      test_reset;
      test_tlr_walk;
      test_ir_scan;
      test_extest_dr;
      test_bypass;
      test_trst;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
